game_pacer: RTL and testbench

Parametrised pacing and game-state controller for the road-fighter top level. It owns the IDLE/RUN/PAUSE/CRASH state machine, the difficulty level, the scroll tick (`upsig`), the fast-scroll tick (`upsig_fast`), a multi-channel enemy drop schedule and the survival score. It sits between the pad and debounce logic and the `main` renderer, replacing the ad-hoc accelerate, drop and score counters in `game`. Speed decrements, drop channel count and score width are all parameters.

---
 rtl/game_pacer.sv | 152 +++++++++++++++
 tb/tb_game_pacer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/game_pacer.sv
// Game-state FSM, difficulty level, scroll/fast/drop pacing and survival score.
// Define GAME_PACER_PAUSE_EN to enable the PAUSE state (start toggles RUN/PAUSE).

module game_pacer_drop #(
  parameter int unsigned    DW   = 8,
  parameter logic [DW-1:0]  INIT = '0
) (
  input  logic          clk,
  input  logic          reset2,
  input  logic          run,
  input  logic          restart,
  input  logic [DW-1:0] d_m1,
  output logic          pulse
);
  logic [DW-1:0] cnt;

  // >= rather than == so a level-up that shrinks D never strands the count
  assign pulse = run && (cnt >= d_m1);

  always_ff @(posedge clk or negedge reset2)
    if (!reset2)      cnt <= '0;
    else if (restart) cnt <= INIT;
    else if (run)     cnt <= pulse ? '0 : cnt + 1'b1;
endmodule

module game_pacer #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BASE_PERIOD  = 131071,
  parameter int unsigned PERIOD_DEC   = 7000,
  parameter int unsigned DROP_PERIOD  = 26568693,
  parameter int unsigned DROP_DEC     = 896000,
  parameter int unsigned LEVELS       = 8,
  parameter int unsigned LEVEL_CYCLES = 200000000,
  parameter int unsigned CRASH_CYCLES = 100000000,
  parameter int unsigned DROP_CH      = 2,
  parameter int unsigned SCORE_W      = 6
) (
  input  logic                      clk,
  input  logic                      reset2,
  input  logic                      start_n,
  input  logic                      colision,
  output logic                      upsig,
  output logic                      upsig_fast,
  output logic [DROP_CH-1:0]        drop,
  output logic                      alive,
  output logic [$clog2(LEVELS)-1:0] level,
  output logic [1:0]                state,
  output logic [SCORE_W-1:0]        total_score
);
  localparam int unsigned LVW = $clog2(LEVELS);
  localparam int unsigned CW  = (BASE_PERIOD  > 2) ? $clog2(BASE_PERIOD)  : 1;
  localparam int unsigned DW  = (DROP_PERIOD  > 2) ? $clog2(DROP_PERIOD)  : 1;
  localparam int unsigned LCW = (LEVEL_CYCLES > 2) ? $clog2(LEVEL_CYCLES) : 1;
  localparam int unsigned SCW = (CLK_HZ       > 2) ? $clog2(CLK_HZ)       : 1;
  localparam int unsigned CRW = (CRASH_CYCLES > 2) ? $clog2(CRASH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_CRASH = 2'd3} state_t;

  state_t          cur, nxt;
  logic            start_q, start_ev, run, restart;
  logic [CW-1:0]   scnt, fcnt, p_m1, f_m1;
  logic [DW-1:0]   d_m1;
  logic [LCW-1:0]  lcnt;
  logic [SCW-1:0]  sec;
  logic [CRW-1:0]  crash_cnt;
  logic [31:0]     p32;

  // Edge register idles high: a press is the high->low transition of start_n
  always_ff @(posedge clk or negedge reset2)
    if (!reset2) start_q <= 1'b1;
    else         start_q <= start_n;

  assign start_ev = !start_n && start_q;

  always_ff @(posedge clk or negedge reset2)
    if (!reset2) cur <= S_IDLE;
    else         cur <= nxt;

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (start_ev) nxt = S_RUN;
      S_RUN:   if (colision) nxt = S_CRASH;
`ifdef GAME_PACER_PAUSE_EN
               else if (start_ev) nxt = S_PAUSE;
      S_PAUSE: if (start_ev) nxt = S_RUN;
`else
      S_PAUSE: nxt = S_IDLE;
`endif
      S_CRASH: if (crash_cnt == CRW'(CRASH_CYCLES - 1)) nxt = S_RUN;
      default: nxt = S_IDLE;
    endcase
  end

  assign run     = (cur == S_RUN);
  // PAUSE->RUN resumes; only IDLE/CRASH->RUN re-seeds the pacing counters
  assign restart = (nxt == S_RUN) && (cur == S_IDLE || cur == S_CRASH);
  assign alive   = run;
  assign state   = cur;

  assign p32  = BASE_PERIOD - 32'(level) * PERIOD_DEC;
  assign p_m1 = CW'(p32 - 32'd1);
  assign f_m1 = CW'(p32 - (p32 >> 3) - 32'd1);
  assign d_m1 = DW'(DROP_PERIOD - 32'(level) * DROP_DEC - 32'd1);

  assign upsig      = run && (scnt >= p_m1);
  assign upsig_fast = run && (fcnt >= f_m1);

  always_ff @(posedge clk or negedge reset2)
    if (!reset2)              crash_cnt <= '0;
    else if (cur == S_CRASH)  crash_cnt <= crash_cnt + 1'b1;
    else                      crash_cnt <= '0;

  always_ff @(posedge clk or negedge reset2)
    if (!reset2) begin
      scnt <= '0; fcnt <= '0; lcnt <= '0; level <= '0;
      sec  <= '0; total_score <= '0;
    end else if (restart) begin
      scnt <= '0; fcnt <= '0; lcnt <= '0; level <= '0;
      // score survives a crash; only a fresh game clears it
      if (cur == S_IDLE) begin
        sec <= '0; total_score <= '0;
      end
    end else if (run) begin
      scnt <= upsig      ? '0 : scnt + 1'b1;
      fcnt <= upsig_fast ? '0 : fcnt + 1'b1;
      if (lcnt == LCW'(LEVEL_CYCLES - 1)) begin
        lcnt <= '0;
        if (level != LVW'(LEVELS - 1)) level <= level + 1'b1;
      end else begin
        lcnt <= lcnt + 1'b1;
      end
      if (sec == SCW'(CLK_HZ - 1)) begin
        sec <= '0;
        if (total_score != '1) total_score <= total_score + 1'b1;
      end else begin
        sec <= sec + 1'b1;
      end
    end

  for (genvar k = 0; k < DROP_CH; k++) begin : g_drop
    localparam int unsigned OFS = k * (DROP_PERIOD / DROP_CH);
    game_pacer_drop #(.DW(DW), .INIT(DW'(OFS))) u_ch (
      .clk     (clk),
      .reset2  (reset2),
      .run     (run),
      .restart (restart),
      .d_m1    (d_m1),
      .pulse   (drop[k])
    );
  end
endmodule

// File: tb/tb_game_pacer.sv
// Directed bench for game_pacer: pulse schedule scoreboard plus state/level/score spot checks.
// Honours GAME_PACER_PAUSE_EN so the pause scenario checks the matching behaviour.
module tb_game_pacer;
  localparam int BASE = 40, PDEC = 8, DROPP = 100, DDEC = 20, LEVELS = 3;
  localparam int LCYC = 200, CRC = 50, HZ = 100, DCH = 2, SW = 3;
`ifdef GAME_PACER_PAUSE_EN
  localparam int SH = 30;
  localparam int PST = 2;
`else
  localparam int SH = 0;
  localparam int PST = 1;
`endif

  logic clk = 1'b0, reset2, start_n, colision;
  logic upsig, upsig_fast, alive;
  logic [DCH-1:0] drop;
  logic [1:0] level, state;
  logic [SW-1:0] total_score;

  int total = 0, bad = 0, cyc = 0, rs = 0;
  bit chk = 1'b0;
  int q [4][$];   // expected pulse cycles: upsig, upsig_fast, drop[0], drop[1]

  game_pacer #(
    .CLK_HZ(HZ), .BASE_PERIOD(BASE), .PERIOD_DEC(PDEC), .DROP_PERIOD(DROPP),
    .DROP_DEC(DDEC), .LEVELS(LEVELS), .LEVEL_CYCLES(LCYC), .CRASH_CYCLES(CRC),
    .DROP_CH(DCH), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset2(reset2), .start_n(start_n), .colision(colision),
    .upsig(upsig), .upsig_fast(upsig_fast), .drop(drop), .alive(alive),
    .level(level), .state(state), .total_score(total_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pops the scoreboard: each pulse output must be high exactly on its expected cycles
  always @(negedge clk) begin
    if (chk) begin
      logic [3:0] obs;
      obs = {drop[1], drop[0], upsig_fast, upsig};
      for (int i = 0; i < 4; i++) begin
        bit e;
        e = 1'b0;
        while (q[i].size() > 0 && q[i][0] < cyc) void'(q[i].pop_front());
        if (q[i].size() > 0 && q[i][0] == cyc) begin
          e = 1'b1;
          void'(q[i].pop_front());
        end
        total++;
        assert (obs[i] === e) else begin
          bad++;
          $error("FAIL pulse%0d cyc=%0d observed=%b expected=%b", i, cyc, obs[i], e);
        end
      end
      total++;
      assert (level <= 2'(LEVELS - 1)) else begin
        bad++;
        $error("FAIL level_max observed=%0d expected<=%0d", level, LEVELS - 1);
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Spec-level model of one RUN segment starting from a fresh level-0 entry
  task automatic push_sched(input int start, input int nrun, input int pause_at, input int shift);
    int sc = 0, fc = 0, lv = 0, lc = 0;
    int dc [2];
    dc[0] = 0;
    dc[1] = DROPP / DCH;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int n = 1; n <= nrun; n++) begin
      int p, f, d, w;
      p = BASE - lv * PDEC;
      f = p - (p >> 3);
      d = DROPP - lv * DDEC;
      w = start + n - 1 + ((n > pause_at) ? shift : 0);
      if (sc >= p - 1) begin q[0].push_back(w); sc = 0; end else sc++;
      if (fc >= f - 1) begin q[1].push_back(w); fc = 0; end else fc++;
      for (int k = 0; k < DCH; k++)
        if (dc[k] >= d - 1) begin q[2 + k].push_back(w); dc[k] = 0; end else dc[k]++;
      if (lc == LCYC - 1) begin lc = 0; if (lv < LEVELS - 1) lv++; end else lc++;
    end
  endtask

  // Counts CRASH cycles (bounded) and returns the wall index of the first RUN cycle after it
  task automatic crash_phase(input int exp_score, output int start);
    int ncr = 0;
    for (int i = 0; i < 200 && state == 2'd3; i++) begin
      ncr++;
      chk_eq("crash_alive", alive, 0);
      chk_eq("crash_score", total_score, exp_score);
      @(negedge clk);
    end
    chk_eq("crash_len", ncr, CRC);
    chk_eq("restart_state", state, 1);
    chk_eq("restart_level", level, 0);
    chk_eq("restart_score", total_score, exp_score);
    start = cyc;
  endtask

  initial begin
    reset2 = 1'b0; start_n = 1'b1; colision = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_state", state, 0);
    chk_eq("rst_level", level, 0);
    chk_eq("rst_score", total_score, 0);
    chk_eq("rst_up", upsig, 0);
    chk_eq("rst_fast", upsig_fast, 0);
    chk_eq("rst_drop", drop, 0);
    chk_eq("rst_alive", alive, 0);
    reset2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("idle_state", state, 0);

    // Run A: start from IDLE, collide at RUN cycle 130
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    rs = cyc;
    chk_eq("start_state", state, 1);
    chk_eq("start_alive", alive, 1);
    push_sched(rs, 130, 1 << 30, 0);
    chk = 1'b1;
    wait_cyc(rs + 34); chk_eq("a_fast35", upsig_fast, 1);
    wait_cyc(rs + 38); chk_eq("a_up39", upsig, 0);
    wait_cyc(rs + 39); chk_eq("a_up40", upsig, 1);
    wait_cyc(rs + 49); chk_eq("a_drop1_50", drop, 2'b10);
    wait_cyc(rs + 99); chk_eq("a_drop0_100", drop, 2'b01);
    chk_eq("a_score100", total_score, 0);
    wait_cyc(rs + 100); chk_eq("a_score101", total_score, 1);
    wait_cyc(rs + 129); colision = 1'b1;
    @(negedge clk); colision = 1'b0;
    chk_eq("a_crash_state", state, 3);
    crash_phase(1, rs);

    // Run B: levels, period shrink, score saturation
    push_sched(rs, 1320, 1 << 30, 0);
    wait_cyc(rs + 39);   chk_eq("b_up40", upsig, 1);
    wait_cyc(rs + 199);  chk_eq("b_lvl200", level, 0);
    wait_cyc(rs + 200);  chk_eq("b_lvl201", level, 1);
    wait_cyc(rs + 231);  chk_eq("b_up232", upsig, 1);
    wait_cyc(rs + 400);  chk_eq("b_lvl401", level, 2);
    wait_cyc(rs + 419);  chk_eq("b_score420", total_score, 5);
    wait_cyc(rs + 569);  chk_eq("b_score570", total_score, 6);
    wait_cyc(rs + 570);  chk_eq("b_score571", total_score, 7);
    wait_cyc(rs + 1319); chk_eq("b_score_sat", total_score, 7);
    chk_eq("b_lvl_end", level, 2);
    colision = 1'b1;
    @(negedge clk); colision = 1'b0;
    crash_phase(7, rs);

    // Run C: start event at RUN cycle 20, second one 30 cycles later
    push_sched(rs, 90, 20, SH);
    wait_cyc(rs + 19); start_n = 1'b0;
    @(negedge clk); start_n = 1'b1;
    wait_cyc(rs + 30); chk_eq("c_pause_state", state, PST);
    chk_eq("c_pause_alive", alive, (PST == 1));
    wait_cyc(rs + 39); chk_eq("c_up40_wall", upsig, (SH == 0));
    wait_cyc(rs + 49); start_n = 1'b0;
    @(negedge clk); start_n = 1'b1;
    wait_cyc(rs + 69); chk_eq("c_up_shift", upsig, (SH != 0));
    chk_eq("c_resume_state", state, 1);
    wait_cyc(rs + 89 + SH);

    // Start event and collision together, then reset during CRASH
    @(negedge clk);
    start_n = 1'b0; colision = 1'b1;
    @(negedge clk);
    start_n = 1'b1; colision = 1'b0;
    chk_eq("both_state", state, 3);
    repeat (5) @(negedge clk);
    chk = 1'b0;
    #2 reset2 = 1'b0;
    #1;
    chk_eq("arst_state", state, 0);
    chk_eq("arst_level", level, 0);
    chk_eq("arst_score", total_score, 0);
    chk_eq("arst_up", upsig, 0);
    chk_eq("arst_fast", upsig_fast, 0);
    chk_eq("arst_drop", drop, 0);
    chk_eq("arst_alive", alive, 0);
    @(negedge clk); reset2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("post_rst_state", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
